// File: rtl/main_ctr_fsm.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback.
// Define MAIN_CTR_ADDI_EN to add the addi path (ADDI_EX, ADDI_WB).
module main_ctr_fsm #(
    parameter int FETCH_IDLE_PC = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       memReady,
    output logic [1:0] aluOp,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSource,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       illegalOp,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
`ifdef MAIN_CTR_ADDI_EN
    localparam logic [3:0] S_ADDI_EX = 4'd10;
    localparam logic [3:0] S_ADDI_WB = 4'd11;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_q, state_d;
    logic [5:0] opc_q, opc_d;

    // The branch decision on zero is made in the datapath, not here.
    logic zero_unused;
    assign zero_unused = zero;

    assign state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        opc_d       = opc_q;
        aluOp       = 2'b00;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        pcSource    = 2'b00;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        regWrite    = 1'b0;
        illegalOp   = 1'b0;

        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = (FETCH_IDLE_PC != 0) ? memReady : 1'b1;
                if (memReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                opc_d   = opcode;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MAIN_CTR_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EX;
`endif
                    default: begin
                        illegalOp = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                // Uses the opcode captured in DECODE; the IR may have moved on.
                if (opc_q == OP_LW)      state_d = S_MEMRD;
                else if (opc_q == OP_SW) state_d = S_MEMWR;
                else                     state_d = S_FETCH;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                if (memReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                if (memReady) state_d = S_FETCH;
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
                state_d = S_RWB;
            end
            S_RWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
                state_d  = S_FETCH;
            end
`ifdef MAIN_CTR_ADDI_EN
            S_ADDI_EX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase

        // State is already FETCH under reset; keep every write strobe quiet too.
        if (reset) begin
            irWrite     = 1'b0;
            pcWrite     = 1'b0;
            memWrite    = 1'b0;
            regWrite    = 1'b0;
            pcWriteCond = 1'b0;
            illegalOp   = 1'b0;
        end
    end

endmodule

// File: doc/main_ctr_fsm.md
# main_ctr_fsm

- Multicycle MIPS main control unit.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives `aluOp` into the ALU control decoder, plus all datapath enables and multiplexer selects.
- Holds in memory states until the unified instruction/data memory reports ready.

## Interface
Parameters:
- `FETCH_IDLE_PC`, default 0: if 1, `pcWrite` is withheld in FETCH while `memReady`=0 (fixed at 1 in tapeout config; 0 is for bring-up only).

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `opcode`  in  6  instruction[31:26]; sampled in DECODE
- `zero`  in  1  ALU zero flag; used in BRANCH
- `memReady`  in  1  memory completes the current read or write this cycle
- `aluOp`  out  2  00 add, 01 subtract, 10 decode `funct`
- `aluSrcA`  out  1  0 = PC, 1 = register A
- `aluSrcB`  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- `pcSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `iorD`, `memRead`, `memWrite`, `irWrite`, `pcWrite`, `pcWriteCond`, `regDst`, `memToReg`, `regWrite`  out  1 each  standard multicycle strobes and selects
- `illegalOp`  out  1  one-cycle pulse on an undecodable opcode
- `state`  out  4  current state code, for debug

## Operation
- One state register, asynchronously reset to FETCH.
- Outputs are decoded from state. `irWrite`, `pcWrite`, `memWrite` and `regWrite` in memory states are additionally gated by `memReady` as listed.
- Any strobe or select not listed for a state is 0.

States, with codes, outputs and next state:
- FETCH(0): `memRead`=1, `aluSrcB`=01.
  - `irWrite` = `pcWrite` = `memReady`.
  - Next: DECODE if `memReady`, else stay in FETCH.
- DECODE(1): `aluSrcB`=11 (branch target into ALUOut).
  - Next by opcode: 000000 → EXEC; 100011 or 101011 → MEMADR; 000100 → BRANCH; 000010 → JUMP; 001000 → ADDI_EX (macro only).
  - Any other opcode: pulse `illegalOp`, next FETCH.
- MEMADR(2): `aluSrcA`=1, `aluSrcB`=10. Next MEMRD for lw, MEMWR for sw, using the opcode latched in DECODE.
- MEMRD(3): `memRead`=1, `iorD`=1. Next MEMWB if `memReady`, else stay.
- MEMWB(4): `regWrite`=1, `memToReg`=1, `regDst`=0. Next FETCH.
- MEMWR(5): `memWrite`=1, `iorD`=1. Next FETCH if `memReady`, else stay.
- EXEC(6): `aluSrcA`=1, `aluSrcB`=00, `aluOp`=10. Next RWB.
- RWB(7): `regWrite`=1, `regDst`=1. Next FETCH.
- BRANCH(8): `aluSrcA`=1, `aluOp`=01, `pcWriteCond`=1, `pcSource`=01. Next FETCH.
  - The PC updates only when `zero`=1; the datapath ANDs `pcWriteCond` with `zero`.
- JUMP(9): `pcWrite`=1, `pcSource`=10. Next FETCH.
- ADDI_EX(10): `aluSrcA`=1, `aluSrcB`=10, `aluOp`=00. Next ADDI_WB.
- ADDI_WB(11): `regWrite`=1, `regDst`=0, `memToReg`=0. Next FETCH.
- Codes 12–15 are unreachable. If reached, all outputs are 0 and the next state is FETCH.

Opcode handling:
- `opcode` is latched into an internal 6-bit register on the DECODE cycle.
- MEMADR selects its branch from this latched value, so the IR may change after DECODE without effect.

## Timing
- Reset: `state`=0, and `irWrite`=`pcWrite`=0 for as long as `reset` is high. Other outputs take their FETCH values: `memRead`=1, `aluSrcB`=01, everything else 0.
- Cycles per instruction with `memReady` tied high: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2.
- Each wait cycle on `memReady` in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- `memReady` is sampled only in FETCH, MEMRD and MEMWR; it is ignored in all other states.
- Reset asserted mid-instruction: the state returns to FETCH immediately (asynchronously). No strobe may be asserted while `reset` is high.
- `illegalOp` is high for exactly the one DECODE cycle of the illegal opcode.

## Configuration
- `MAIN_CTR_ADDI_EN` defined: opcode 001000 takes DECODE → ADDI_EX → ADDI_WB → FETCH.
- Not defined: 001000 is illegal. `illegalOp` pulses, ADDI_EX and ADDI_WB are not synthesized, and codes 10–11 behave as unreachable.

## Test plan
- R-type, opcode 000000, `memReady`=1 → states 0,1,6,7,0. `aluOp`=10 in state 6 only; `regWrite`=1 and `regDst`=1 in state 7.
- lw, opcode 100011, `memReady` low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0. `memRead`=`iorD`=1 throughout MEMRD; `memToReg`=1 in state 4.
- beq, opcode 000100, run with `zero`=1 and again with `zero`=0 → states 0,1,8,0 both times. `aluOp`=01 and `pcWriteCond`=1 in state 8 in both runs.
- Illegal opcode 111111 → states 0,1,0. `illegalOp`=1 only during state 1; no write strobes asserted.
- Reset pulsed during MEMWR with `memReady`=0 → `state`=0 immediately, `memWrite` and `pcWrite` drop to 0. After release, the next fetch completes normally.
- addi, opcode 001000 → with the macro: states 0,1,10,11,0, `aluSrcB`=10 in state 10. Without the macro: states 0,1,0 with an `illegalOp` pulse.
